// File: rtl/countdown_ctrl_if.sv
// Control and display bundle between the pushbutton/setting front end and countdown_ctrl.
// master = front end driving triggers and target; slave = the sequencing controller.
interface countdown_ctrl_if #(
  parameter int BCD_BITS = 12
);
  logic                pause_trig;
  logic                restart_trig;
  logic                mode_switch;
  logic                count_up;
  logic [BCD_BITS-1:0] q_target;
  logic [BCD_BITS-1:0] count;
  logic                is_start;
  logic                is_pause;
  logic                is_setting;
  logic                done;
  logic                done_pulse;

  modport master (
    output pause_trig, restart_trig, mode_switch, count_up, q_target,
    input  count, is_start, is_pause, is_setting, done, done_pulse
  );

  modport slave (
    input  pause_trig, restart_trig, mode_switch, count_up, q_target,
    output count, is_start, is_pause, is_setting, done, done_pulse
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Run-state sequencer for the 3-digit BCD stopwatch/countdown: owns the state machine,
// tick prescaler and BCD counter, and drives display value and status flags.
module countdown_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int BCD_BITS = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  countdown_ctrl_if.slave   bus
);

  localparam int NDIG = BCD_BITS / 4;
  localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] ST_START   = 2'd0;
  localparam logic [1:0] ST_PAUSE   = 2'd1;
  localparam logic [1:0] ST_SETTING = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]          state;
  logic [BCD_BITS-1:0] target_reg;
  logic                dir_reg;
  logic [BCD_BITS-1:0] count_r;
  logic [PW-1:0]       presc;
  logic                done_pulse_r;
  logic                tick;
  logic [BCD_BITS-1:0] terminal;
  logic [BCD_BITS-1:0] stepped;

  function automatic logic bcd_valid(input logic [BCD_BITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NDIG; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [BCD_BITS-1:0] bcd_dec(input logic [BCD_BITS-1:0] v);
    logic [BCD_BITS-1:0] r;
    logic                borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [BCD_BITS-1:0] bcd_inc(input logic [BCD_BITS-1:0] v);
    logic [BCD_BITS-1:0] r;
    logic                carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick     = (state == ST_START) && (presc == PMAX);
  assign terminal = dir_reg ? target_reg : '0;
  assign stepped  = dir_reg ? bcd_inc(count_r) : bcd_dec(count_r);

  // Reload samples the direction level here; it is ignored at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_PAUSE;
      target_reg   <= '0;
      dir_reg      <= 1'b0;
      count_r      <= '0;
      presc        <= '0;
      done_pulse_r <= 1'b0;
    end else begin
      done_pulse_r <= 1'b0;
      presc        <= '0;
      if (bus.mode_switch) begin
        state <= ST_SETTING;
        if (state == ST_SETTING && bcd_valid(bus.q_target)) begin
          target_reg <= bus.q_target;
          count_r    <= bus.q_target;
        end else if (state == ST_SETTING) begin
          count_r    <= target_reg;
        end
      end else if (state == ST_SETTING || (bus.restart_trig)) begin
        state   <= ST_PAUSE;
        dir_reg <= bus.count_up;
        count_r <= bus.count_up ? '0 : target_reg;
      end else begin
        case (state)
          ST_PAUSE: begin
            if (bus.pause_trig) begin
              if (count_r == terminal) begin
                state        <= ST_DONE;
                done_pulse_r <= 1'b1;
              end else begin
                state <= ST_START;
              end
            end
          end
          ST_START: begin
            if (bus.pause_trig) begin
              state <= ST_PAUSE;
            end else if (tick) begin
              count_r <= stepped;
              if (stepped == terminal) begin
                state        <= ST_DONE;
                done_pulse_r <= 1'b1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.count      = count_r;
  assign bus.is_start   = (state == ST_START);
  assign bus.is_pause   = (state == ST_PAUSE);
  assign bus.is_setting = (state == ST_SETTING);
  assign bus.done       = (state == ST_DONE);
  assign bus.done_pulse = done_pulse_r;

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the 3-digit BCD stopwatch/countdown datapath. It consumes one-cycle `pause_trig`/`restart_trig` pulses from the pushbutton front end, the level `mode_switch`, and a BCD target from the setting logic. It owns the run state machine, tick prescaler and BCD counter, and drives the display value plus status flags to the 7-segment and LED logic.

## Interface
- `TICK_DIV`, 100000: clk cycles per count step; must be ≥2.
- `BCD_BITS`, 12: counter width, 3 BCD digits; fixed, not to be overridden.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pause_trig` input 1: one-cycle pulse that toggles run/pause.
- `restart_trig` input 1: one-cycle pulse that reloads the counter.
- `mode_switch` input 1: level signal; 1 selects setting mode.
- `count_up` input 1: level signal; 1 counts up 000→target, 0 counts down target→000. Sampled only on reload.
- `q_target` input 12: BCD target from the setting logic.
- `count` output 12: current BCD value for the display.
- `is_start` output 1: state is START.
- `is_pause` output 1: state is PAUSE.
- `is_setting` output 1: state is SETTING.
- `done` output 1: state is DONE.
- `done_pulse` output 1: one cycle on entry to DONE.

## Operation
- State encoding: START=0, PAUSE=1, SETTING=2, DONE=3.
- Registers:
  - `target_reg` (12 bits)
  - `dir_reg` (1 bit)
  - `count` (12 bits)
  - prescaler, `$clog2(TICK_DIV)` bits
- Reset values:
  - state=PAUSE, `count`=000, `target_reg`=000, `dir_reg`=0 (down).
  - Prescaler=0.
  - Flags: `is_pause`=1; all other status outputs 0.
- Reload means: `dir_reg`←`count_up`. Then `count`←000 if `count_up`=1, else `count`←`target_reg`.
- Terminal value: 000 when `dir_reg`=0; `target_reg` when `dir_reg`=1.
- Priority per cycle: `mode_switch` > `restart_trig` > `pause_trig` > tick.
- `mode_switch`=1 in any state → SETTING.
- SETTING:
  - Each cycle, `target_reg`←`q_target` only if all three nibbles ≤9. Otherwise `target_reg` holds.
  - `count` mirrors the new `target_reg`.
  - When `mode_switch`=0: reload, → PAUSE.
- PAUSE:
  - `restart_trig`: reload, stay in PAUSE.
  - `pause_trig`: → START if `count`≠terminal; → DONE if `count`=terminal.
- START:
  - `restart_trig`: reload, → PAUSE.
  - `pause_trig`: → PAUSE; `count` holds.
  - Tick: step `count` one unit. If the stepped value equals terminal → DONE.
- DONE:
  - `count` holds at terminal; `pause_trig` is ignored.
  - `restart_trig`: reload, → PAUSE.
- BCD step down: decrement digit 0. A digit at 0 borrows and becomes 9. 000 is never stepped, because the terminal check fires first.
- BCD step up: increment digit 0. A digit at 9 carries and becomes 0. Values never pass `target_reg`, so 999 does not wrap.
- Prescaler:
  - Counts only in START; held at 0 in every other state, so each START entry restarts a full tick period.
  - Tick is asserted when prescaler = `TICK_DIV`−1; the prescaler then returns to 0.
- `rst_n` low mid-run: immediate return to the reset values, regardless of clock.

## Timing
- All outputs are registered. Status flags are decoded from the state register and are one-hot across the four states.
- A trigger sampled at edge k takes effect (new state, new `count`) at edge k; it is visible from then until edge k+1.
- The first step occurs `TICK_DIV` cycles after the edge that entered START. Subsequent steps follow every `TICK_DIV` cycles.
- `done` rises on the same edge as the final step. `done_pulse` is high for exactly that one cycle.
- A `pause_trig` on the same cycle as a tick wins: no step, → PAUSE.
- A `restart_trig` on a tick cycle wins: reload, no step.
- `mode_switch` rise/fall latency is 1 edge. A `q_target` change in SETTING appears on `count` 1 edge later.
- Triggers are assumed single-cycle. A pulse held for N cycles acts N times: `pause_trig` toggles; `restart_trig` reloads each time.

## Test plan
Benches use `TICK_DIV`=4.
- Reset and idle: `rst_n` low, then high. Expect `count`=000 and `is_pause`=1. Triggers idle for 20 cycles: no change.
- Setting then countdown:
  - Drive `mode_switch`=1, `q_target`=12'h012, `count_up`=0, then `mode_switch`=0. Expect `count`=012 and PAUSE.
  - Pulse `pause_trig`. Expect steps every 4 cycles: 011, 010, 009, …, 001, 000.
  - On reaching 000: `done`=1 and `done_pulse` high for one cycle. A further `pause_trig` is ignored.
- Count-up with pause/resume:
  - Target 12'h005, `count_up`=1, reload. Expect `count`=000.
  - Run to 002, pulse `pause_trig`: `count` holds for 10 cycles.
  - Resume: next step arrives 4 cycles later. DONE at 005.
- Invalid target and zero target:
  - `q_target`=12'h0A3 in SETTING: `target_reg` holds its previous value.
  - Target 000 in down mode, `pause_trig`: immediate DONE.
- Priority:
  - `restart_trig` on the tick cycle at `count`=007 (target 009): `count`=009 and PAUSE, with no step.
  - `mode_switch`=1 together with `pause_trig`: SETTING.
- Asynchronous reset mid-run: assert `rst_n` low between clock edges while in START at `count`=004. Outputs must return to the reset values before the next edge.
